// File: rtl/uart_baud_nco_if.sv
// uart_baud_nco_if: rate control and tick bundle between the
// baud NCO and the UART TX/RX shift logic.
interface uart_baud_nco_if #(
  parameter int ACC_WIDTH = 16
);
  logic                 Enable;
  logic                 Resync;
  logic [2:0]           Sel_Baud_Rate;
  logic [ACC_WIDTH-1:0] Custom_inc;
  logic                 Sample_tick;
  logic                 Bit_tick;
  logic                 Clock;
  logic                 Sample_clock;
  logic                 Rate_pending;

  modport master (
    output Enable,
    output Resync,
    output Sel_Baud_Rate,
    output Custom_inc,
    input  Sample_tick,
    input  Bit_tick,
    input  Clock,
    input  Sample_clock,
    input  Rate_pending
  );

  modport slave (
    input  Enable,
    input  Resync,
    input  Sel_Baud_Rate,
    input  Custom_inc,
    output Sample_tick,
    output Bit_tick,
    output Clock,
    output Sample_clock,
    output Rate_pending
  );
endinterface

// File: rtl/uart_baud_nco.sv
// uart_baud_nco: phase-accumulator baud generator producing
// sample ticks, bit ticks and baud/sample square waves.
module uart_baud_nco #(
  parameter int ACC_WIDTH  = 16,
  parameter int OVERSAMPLE = 16,
  parameter logic [ACC_WIDTH-1:0] INC_0 = ACC_WIDTH'(13),
  parameter logic [ACC_WIDTH-1:0] INC_1 = ACC_WIDTH'(25),
  parameter logic [ACC_WIDTH-1:0] INC_2 = ACC_WIDTH'(50),
  parameter logic [ACC_WIDTH-1:0] INC_3 = ACC_WIDTH'(101),
  parameter logic [ACC_WIDTH-1:0] INC_4 = ACC_WIDTH'(201),
  parameter logic [ACC_WIDTH-1:0] INC_5 = ACC_WIDTH'(403),
  parameter logic [ACC_WIDTH-1:0] INC_6 = ACC_WIDTH'(604)
) (
  input  logic           Sys_clock,
  input  logic           reset,
  uart_baud_nco_if.slave bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_HALF =
    CW'(OVERSAMPLE / 2);

  logic [ACC_WIDTH-1:0] inc_sel;
  logic [ACC_WIDTH-1:0] inc_active;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH:0]   sum;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_nxt;
  logic                 carry;
  logic                 wrap;
  logic                 restart;
  logic                 st_q;
  logic                 bt_q;
  logic                 clk_q;
  logic                 sclk_q;

  always_comb begin
    inc_sel = bus.Custom_inc;
    unique case (bus.Sel_Baud_Rate)
      3'd0:    inc_sel = INC_0;
      3'd1:    inc_sel = INC_1;
      3'd2:    inc_sel = INC_2;
      3'd3:    inc_sel = INC_3;
      3'd4:    inc_sel = INC_4;
      3'd5:    inc_sel = INC_5;
      3'd6:    inc_sel = INC_6;
      default: inc_sel = bus.Custom_inc;
    endcase
  end

  assign sum   = {1'b0, acc} + {1'b0, inc_active};
  assign carry = sum[ACC_WIDTH];
  assign wrap  = carry && (cnt == CNT_LAST);

  always_comb begin
    cnt_nxt = cnt;
    if (carry) begin
      cnt_nxt = wrap ? '0 : cnt + 1'b1;
    end
  end

  // Disable and resync restart the phase exactly like reset
  assign restart = !bus.Enable || bus.Resync;

  always_ff @(posedge Sys_clock) begin
    if (reset || restart) begin
      acc        <= '0;
      cnt        <= '0;
      st_q       <= 1'b0;
      bt_q       <= 1'b0;
      sclk_q     <= 1'b0;
      clk_q      <= 1'b1;
      inc_active <= inc_sel;
    end else begin
      acc   <= sum[ACC_WIDTH-1:0];
      cnt   <= cnt_nxt;
      st_q  <= carry;
      bt_q  <= wrap;
      clk_q <= (cnt_nxt < CNT_HALF);
      if (carry) begin
        sclk_q <= !sclk_q;
      end
      // New rate only lands on a bit boundary: no runt bits
      if (wrap) begin
        inc_active <= inc_sel;
      end
    end
  end

  assign bus.Sample_tick  = st_q;
  assign bus.Bit_tick     = bt_q;
  assign bus.Clock        = clk_q;
  assign bus.Sample_clock = sclk_q;
  assign bus.Rate_pending = (inc_sel != inc_active);

endmodule
